// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// No logic of its own; imported by rf_wport_arb and rr_pick.
// rr_first is a reference one-hot round-robin picker for up to 8 requesters.
package rf_arb_pkg;

  localparam int RN_W = 5;
  localparam logic [RN_W-1:0] RZERO = 5'd0;
  localparam int MAX_REQ = 8;

  // First set bit of valid at or after ptr, wrapping over 8 positions.
  // Unused upper bits must be zero; wrapping over 8 then matches wrapping
  // over the real requester count because ptr is always below that count.
  function automatic logic [MAX_REQ-1:0] rr_first(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0] ptr);
    logic [MAX_REQ-1:0] grant;
    logic [2:0] idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + 3'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rf_wport_arb_rr_pick.sv
// Round-robin pick: rotate request vector by ptr, take lowest set bit, unrotate.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller gates the grant with slot availability.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_pick;
  logic [2*N-1:0] w_unrot;

  // Rotate so that index ptr lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    w_dbl      = {i_valid, i_valid} >> i_ptr;
    w_rot      = w_dbl[N-1:0];
    w_rot_pick = w_rot & (~w_rot + 1'b1);
    w_unrot    = {w_rot_pick, w_rot_pick} << i_ptr;
    o_grant    = w_unrot[2*N-1:N];
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: one registered {we,wn,d} slot fed round-robin.
// Latency: request accepted at edge t drives we/wn/d from t; commits at first unstalled edge.
// Backpressure: req_ready drops while wr_stall holds a valid write; RFARB_FIXED_PRIO_EN selects fixed priority.
module rf_wport_arb
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [RN_W*NREQ-1:0] req_rn,
  input  logic [W*NREQ-1:0]    req_d,
  input  logic                 wr_stall,
  output logic [RN_W-1:0]      wn,
  output logic                 we,
  output logic [W-1:0]         d
);

  logic            r_we;
  logic [RN_W-1:0] r_wn;
  logic [W-1:0]    r_d;

  logic [NREQ-1:0] w_grant;
  logic            w_free;
  logic [RN_W-1:0] w_sel_rn;
  logic [W-1:0]    w_sel_d;

`ifdef RFARB_FIXED_PRIO_EN
  // Lowest index wins; no pointer state exists in this build.
  always_comb begin
    w_grant = req_valid & (~req_valid + 1'b1);
  end
`else
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_ptr_nxt;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Encode the winner index and the pointer value just past it.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gidx = PW'(i);
    end
    w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  end

  // Pointer advances only when a request is actually taken.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_ptr <= '0;
    end else if (w_free && (|w_grant)) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  // Select the winner's register number and data; grant is one-hot.
  always_comb begin
    w_sel_rn = '0;
    w_sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rn = req_rn[RN_W*i +: RN_W];
        w_sel_d  = req_d[W*i +: W];
      end
    end
  end

  // Slot is free when it is empty or is being committed this edge, so
  // back-to-back writes need no bubble. Reset forces ready low.
  always_comb begin
    w_free    = !r_we || !wr_stall;
    req_ready = (clrn && w_free) ? w_grant : '0;
  end

  // Output slot: load winner, clear enable on idle, hold while stalled.
  // r0 writes load wn/d but leave we low so the register file ignores them.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_we <= 1'b0;
      r_wn <= '0;
      r_d  <= '0;
    end else if (w_free) begin
      if (|w_grant) begin
        r_we <= (w_sel_rn != RZERO);
        r_wn <= w_sel_rn;
        r_d  <= w_sel_d;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign we = r_we;
  assign wn = r_wn;
  assign d  = r_d;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Randomized and directed bench for rf_wport_arb against a behavioural model.
// Inputs driven on falling edge; ready sampled 1ns later, slot sampled 1ns after rise.
// Requesters hold request stable until transfer; reset and stalls injected randomly.
module tb_rf_wport_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic               clk;
  logic               clrn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_rn;
  logic [W*NREQ-1:0]  req_d;
  logic               wr_stall;
  logic [4:0]         wn;
  logic               we;
  logic [W-1:0]       d;

  rf_wport_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rn    (req_rn),
    .req_d     (req_d),
    .wr_stall  (wr_stall),
    .wn        (wn),
    .we        (we),
    .d         (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pending request held by each requester until it transfers.
  logic [NREQ-1:0] p_vld;
  logic [4:0]      p_rn [NREQ];
  logic [W-1:0]    p_d  [NREQ];

  // Reference model state: the write slot and the round-robin pointer.
  bit         m_we;
  logic [4:0] m_wn;
  logic [W-1:0] m_d;
  int         m_ptr;
  int         last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check ready, advance model at the edge, check slot.
  task automatic step(input logic rst_n, input logic stall);
    int g;
    int idx;
    bit free;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    clrn      = rst_n;
    wr_stall  = stall;
    req_valid = p_vld;
    for (int i = 0; i < NREQ; i++) begin
      req_rn[5*i +: 5] = p_rn[i];
      req_d[W*i +: W]  = p_d[i];
    end
    g = -1;
    free = !m_we || !stall;
    if (rst_n && free) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef RFARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % NREQ;
`endif
        if (g < 0 && p_vld[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    #1;
    chk("ready", req_ready, exp_rdy);
    last_grant = g;
    @(posedge clk);
    if (!rst_n) begin
      m_we = 0; m_wn = '0; m_d = '0; m_ptr = 0;
    end else if (free) begin
      if (g >= 0) begin
        m_we  = (p_rn[g] != 0);
        m_wn  = p_rn[g];
        m_d   = p_d[g];
        m_ptr = (g + 1) % NREQ;
        p_vld[g] = 1'b0;
      end else begin
        m_we = 0;
      end
    end
    #1;
    chk("we", we, m_we);
    chk("wn", wn, m_wn);
    chk("d", d, m_d);
  endtask

  task automatic fill_all_seq();
    for (int i = 0; i < NREQ; i++) begin
      p_vld[i] = 1'b1;
      p_rn[i]  = 5'(i + 1);
      p_d[i]   = $urandom;
    end
  endtask

  initial begin
    clrn = 1'b0; wr_stall = 1'b0; req_valid = '0; req_rn = '0; req_d = '0;
    p_vld = '0;
    for (int i = 0; i < NREQ; i++) begin p_rn[i] = '0; p_d[i] = '0; end
    m_we = 0; m_wn = '0; m_d = '0; m_ptr = 0; last_grant = -1;

    // Reset with every requester asserting.
    fill_all_seq();
    repeat (3) step(1'b0, 1'b0);

    // All continuously valid: round-robin order from requester 0.
    for (int k = 0; k < 5; k++) begin
      fill_all_seq();
      step(1'b1, 1'b0);
`ifdef RFARB_FIXED_PRIO_EN
      chk("fp_grant", last_grant, 0);
`else
      chk("rr_order", last_grant, k % NREQ);
      chk("rr_wn", wn, (k % NREQ) + 1);
`endif
    end

    // r0 request from requester 2 alone: handshaked, dropped.
    p_vld = '0;
    step(1'b1, 1'b0);
    p_vld[2] = 1'b1; p_rn[2] = 5'd0; p_d[2] = 32'hDEADBEEF;
    step(1'b1, 1'b0);
    chk("r0_grant", last_grant, 2);
    chk("r0_we", we, 0);
    chk("r0_d", d, 32'hDEADBEEF);

    // Stall with others waiting, then commit and reload on the same edge.
    p_vld[1] = 1'b1; p_rn[1] = 5'd5; p_d[1] = 32'h12345678;
    step(1'b1, 1'b0);
    p_vld[0] = 1'b1; p_rn[0] = 5'd9;  p_d[0] = $urandom;
    p_vld[3] = 1'b1; p_rn[3] = 5'd12; p_d[3] = $urandom;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      chk("stall_rdy", last_grant, -1);
      chk("stall_d", d, 32'h12345678);
    end
    step(1'b1, 1'b0);
    chk("unstall_load", last_grant >= 0, 1);

    // Write to r7, then idle.
    p_vld = '0;
    step(1'b1, 1'b0);
    p_vld[0] = 1'b1; p_rn[0] = 5'd7; p_d[0] = $urandom;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("idle_wn", wn, 7);
    chk("idle_we", we, 0);

    // Fixed-priority starvation pattern or round-robin alternation.
    for (int k = 0; k < 6; k++) begin
      p_vld[0] = 1'b1; p_rn[0] = 5'd1; p_d[0] = $urandom;
      p_vld[3] = 1'b1; p_rn[3] = 5'd3; p_d[3] = $urandom;
      step(1'b1, 1'b0);
`ifdef RFARB_FIXED_PRIO_EN
      chk("fp_0_wins", last_grant, 0);
`endif
    end
    p_vld = '0;
    step(1'b1, 1'b0);

    // Randomized traffic with stalls, r0 writes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
          p_vld[i] = 1'b1;
          p_rn[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          p_d[i]   = $urandom;
        end
      end
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wport_arb.md
# rf_wport_arb

Arbiter and sequencer for the CPU register file's single write port. It accepts write requests (register number plus data) from several execution units over valid/ready handshakes and grants one per cycle, round-robin. It drives a registered 5-bit register number, write enable and data word into the 5-32 write-enable decoder and register array. Writes to r0 are accepted and silently discarded.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 32: data width.
- clk  in  1  clock; all state changes on rising edge.
- clrn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  bit i: requester i holds a write request.
- req_ready  out  NREQ  bit i: requester i's request is accepted this cycle. Combinational; at most one bit high (one-hot or zero).
- req_rn  in  5*NREQ  destination register of requester i, in bits [5i+4:5i].
- req_d  in  W*NREQ  write data of requester i, in bits [Wi+W-1:Wi].
- wr_stall  in  1  register file cannot take a write this cycle.
- wn  out  5  registered register number; feeds the decoder's n input.
- we  out  1  registered write enable; feeds the decoder's ena input.
- d  out  W  registered write data.

## Operation
- State:
  - output register {we, wn, d};
  - round-robin pointer ptr, range 0..NREQ-1.
- A request i transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
- The output slot is free when wr_stall==0 or we==0.
- When the slot is free:
  - Search req_valid starting at index ptr, ascending, wrapping modulo NREQ. The first valid index is g; req_ready[g]=1.
  - Next edge: we<=(req_rn[g]!=0), wn<=req_rn[g], d<=req_d[g], ptr<=(g+1) mod NREQ.
- Free slot, no valid request: req_ready=0. Next edge: we<=0; wn, d and ptr hold.
- Slot not free (wr_stall==1 and we==1): req_ready=0, and all state holds.
- The register file commits wn/d on any edge where we==1 and wr_stall==0.
- r0 requests:
  - Are handshaked and advance ptr like any other request.
  - Load we=0, so the write is dropped.
  - wn and d still load the request's values.
- req_valid must stay asserted, with stable rn and d, until the transfer; deassertion before the transfer is a requester error.
- Reset, clrn==0 at an edge: we=0, wn=0, d=0, ptr=0. req_ready=0 during any cycle in which clrn==0.
- Reset mid-stall: the pending write is lost and we=0 on the next cycle.

## Timing
- Latency: a request transferred at edge t has we/wn/d valid from edge t to edge t+1, and commits at the first edge ≥ t+1 with wr_stall==0.
- Throughput: one write per cycle when wr_stall==0.
- A slot freed by commit at edge t+1 can accept a new request at that same edge (no bubble): slot free is evaluated combinationally from wr_stall and the current we.
- req_ready depends combinationally on req_valid, wr_stall, we and ptr only; never on req_d or req_rn.
- Fairness: with all requesters continuously valid and wr_stall==0, each requester is granted exactly once per NREQ cycles.

## Configuration
- RFARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest index always wins.
  - ptr is not implemented.
  - Starvation of higher indices is permitted.
- Not defined: round-robin as above (default).

## Structure
- Package rf_arb_pkg:
  - constant RN_W=5;
  - constant RZERO=5'd0;
  - function rr_first(valid, ptr) returning the one-hot grant.
- Sub-module rr_pick: combinational rotate, priority-select and unrotate of req_valid against ptr. It is bypassed to a plain priority encoder under RFARB_FIXED_PRIO_EN.
- rf_wport_arb holds only the output register, ptr and the handshake logic.

## Test plan
- Reset: hold clrn=0 for 3 cycles with all req_valid=1 -> req_ready=0, we=0, wn=0, d=0. After release, the first grant goes to requester 0.
- Round-robin: NREQ=4, all valid with rn=i+1, wr_stall=0 -> grants 0,1,2,3,0 on consecutive cycles; wn=1,2,3,4,1 one cycle later; we=1 throughout.
- r0 drop: requester 2 alone valid with rn=0, d=32'hDEADBEEF -> req_ready[2]=1, next cycle we=0, and ptr advances to 3.
- Stall: grant rn=5, d=32'h12345678, then wr_stall=1 for 3 cycles with other requests valid -> we=1, wn=5, d held, req_ready=0. At the wr_stall=0 edge the write commits and the next grant loads in the same edge.
- Idle: no requests for 2 cycles after a write to r7 -> we=0, wn stays 7, ptr unchanged.
- Fixed priority (RFARB_FIXED_PRIO_EN): requesters 0 and 3 continuously valid -> requester 0 is granted every cycle and requester 3 never.
